rgb_pwm_decoder: RTL and testbench
==================================

// Module: rgb_pwm_decoder
// PURPOSE
//  Receive end of the on-board RGB PWM link: samples the three active-low PWM
//  LED drive lines and recovers each channel's 4-bit intensity plus the
//  colour-wheel sector (0-5). Used for loop-back self-test of the hue PWM
//  generator and as an input stage for boards that take PWM colour commands.
//  Measurement is alignment-free: it counts low samples over one full PWM frame.
// PARAMETERS
//  PWM_BITS     4     intensity resolution (max code 2^PWM_BITS-1 = 15)
//  STEP_CLKS    512   CLK cycles per PWM step (power of two)
//  FRAME_CLKS   8192  measurement window = 2^PWM_BITS * STEP_CLKS cycles
//  SYNC_STAGES  2     synchronizer flops per input (>=2)
// PORTS
//  CLK         in   1         12 MHz system clock
//  RST         in   1         asynchronous reset, active high
//  pwm_r_n     in   1         red PWM line, active low (low = LED on)
//  pwm_g_n     in   1         green PWM line, active low
//  pwm_b_n     in   1         blue PWM line, active low
//  r_int       out  PWM_BITS  recovered red intensity
//  g_int       out  PWM_BITS  recovered green intensity
//  b_int       out  PWM_BITS  recovered blue intensity
//  sector      out  3         hue sector 0-5; 7 = not on colour wheel
//  meas_valid  out  1         one-cycle strobe: outputs updated this cycle
//  locked      out  1         level: at least one full window published
// BEHAVIOUR
//  - Reset (async assert, sync release): r/g/b_int=0, sector=7, meas_valid=0,
//    locked=0, accumulators=0, window counter=0, FSM=FLUSH.
//  - Inputs are async; each passes a SYNC_STAGES flop chain before use.
//  - FSM: FLUSH holds window counter at 0 for SYNC_STAGES cycles (discards
//    synchronizer contents), then goes to ACQ. ACQ loops forever; only reset
//    returns to FLUSH. Reset mid-window discards the partial window.
//  - ACQ: win_cnt counts 0..FRAME_CLKS-1, wraps to 0. Each cycle, per channel,
//    acc += (synced line == 0). Width clog2(FRAME_CLKS+1) = 14 bits, no overflow.
//  - Terminal cycle (win_cnt==FRAME_CLKS-1): its own sample is included; on
//    that edge: outputs load, meas_valid=1 for the next cycle only, locked=1
//    (sticky), accumulators clear to 0 for the new window. No gap between windows.
//  - Intensity = (acc + STEP_CLKS/2) >> log2(STEP_CLKS), i.e. round half up;
//    saturate to 2^PWM_BITS-1 (all-low frame gives 16 -> 15).
//  - Sector, first match wins, from the just-computed intensities (M=max code):
//      r==M && b==0 && g!=M -> 0 ; g==M && b==0 -> 1 ; g==M && r==0 -> 2 ;
//      b==M && r==0 -> 3 ; b==M && g==0 -> 4 ; r==M && g==0 -> 5 ; else 7.
//  - Outputs are registered and stable between meas_valid strobes.
//  - First meas_valid: exactly SYNC_STAGES+FRAME_CLKS cycles after reset release.
// STRUCTURE
//  - Package rgb_pwm_pkg: PWM_BITS, PWM_MAX, sector_t (SEC_0..SEC_5,
//    SEC_NONE=7), decoder FSM state enum (FLUSH, ACQ), function
//    sector_of(r,g,b) shared with the generator model.
//  - Sub-module pwm_duty_meter (x3): synchronizer, low-count accumulator,
//    round/saturate; inputs clear/terminal from top. Top owns win_cnt, FSM,
//    sector decode and output registers.
// TESTING
//  1 All lines held high, reset released -> strobe at cycle 8194; r=g=b=0,
//    sector=7, locked=1.
//  2 R always low, G low 7*512 of each 8192, B high -> r=15 (saturated),
//    g=7, b=0, sector=0 on every strobe.
//  3 Rounding: G low 3839 cycles/frame -> g=7; 3840 cycles -> g=8.
//  4 Random phase offset (0..8191) of a fixed-duty pattern -> identical
//    intensities every window, independent of offset.
//  5 Behavioural hue generator sweeping 0..359 deg, PWM steps at 512 clks ->
//    each strobe's sector equals sector_of(generator intensities); no 7 seen.
//  6 RST pulsed at win_cnt=4000 -> outputs to reset values immediately;
//    next strobe exactly 8194 cycles after release; no strobe from partial.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB PWM link: intensity width, hue sectors,
// decoder FSM states and the sector classifier used by both ends of the link.
package rgb_pwm_pkg;

    localparam int PWM_BITS = 4;
    localparam int PWM_MAX  = (1 << PWM_BITS) - 1;

    typedef logic [PWM_BITS-1:0] pwm_int_t;

    localparam pwm_int_t PWM_MAX_CODE = pwm_int_t'(PWM_MAX);

    typedef enum logic [2:0] {
        SEC_0    = 3'd0,
        SEC_1    = 3'd1,
        SEC_2    = 3'd2,
        SEC_3    = 3'd3,
        SEC_4    = 3'd4,
        SEC_5    = 3'd5,
        SEC_NONE = 3'd7
    } sector_t;

    typedef enum logic {
        FLUSH = 1'b0,
        ACQ   = 1'b1
    } dec_state_t;

    // Ordered rules: the first matching rule decides, so shared edges of the
    // colour wheel resolve towards the lower-numbered sector.
    function automatic sector_t sector_of(input pwm_int_t r, input pwm_int_t g, input pwm_int_t b);
        sector_t s;
        if (r == PWM_MAX_CODE && b == '0 && g != PWM_MAX_CODE) s = SEC_0;
        else if (g == PWM_MAX_CODE && b == '0)                 s = SEC_1;
        else if (g == PWM_MAX_CODE && r == '0)                 s = SEC_2;
        else if (b == PWM_MAX_CODE && r == '0)                 s = SEC_3;
        else if (b == PWM_MAX_CODE && g == '0)                 s = SEC_4;
        else if (r == PWM_MAX_CODE && g == '0)                 s = SEC_5;
        else                                                   s = SEC_NONE;
        return s;
    endfunction

endpackage

// File: rtl/pwm_duty_meter.sv
// One PWM channel: synchronizes the active-low line, counts low samples over
// a window and presents the rounded, saturated intensity of the window total.
module pwm_duty_meter
    import rgb_pwm_pkg::*;
#(
    parameter int STEP_CLKS   = 512,
    parameter int SYNC_STAGES = 2,
    parameter int ACC_W       = 14
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_line_n,
    input  logic                i_clear,
    input  logic                i_terminal,
    output logic [PWM_BITS-1:0] o_int
);

    localparam int             SHIFT     = $clog2(STEP_CLKS);
    localparam logic [ACC_W:0] HALF_STEP = (ACC_W+1)'(STEP_CLKS / 2);
    localparam logic [ACC_W:0] SAT_LIMIT = (ACC_W+1)'(PWM_MAX);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [ACC_W-1:0]       r_acc;
    logic                   w_low;
    logic [ACC_W-1:0]       w_acc_total;
    logic [ACC_W:0]         w_rounded;
    logic [ACC_W:0]         w_quot;

    // Synchronizer resets to the idle (LED off) level; its contents are
    // discarded by the top-level flush anyway.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_line_n};
    end

    assign w_low       = ~r_sync[SYNC_STAGES-1];
    assign w_acc_total = r_acc + {{(ACC_W-1){1'b0}}, w_low};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of block evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                          r_acc <= '0;
        else if (i_clear || i_terminal)   r_acc <= '0;
        else                              r_acc <= w_acc_total;
    end

    assign w_rounded = {1'b0, w_acc_total} + HALF_STEP;
    assign w_quot    = w_rounded >> SHIFT;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        o_int = PWM_MAX_CODE;
        if (w_quot <= SAT_LIMIT) o_int = w_quot[PWM_BITS-1:0];
    end

endmodule

// File: rtl/rgb_pwm_decoder.sv
// RGB PWM receiver: three duty meters over a shared free-running window,
// registered intensities, hue sector, a per-window strobe and a lock flag.
module rgb_pwm_decoder
    import rgb_pwm_pkg::*;
#(
    parameter int STEP_CLKS   = 512,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                pwm_r_n,
    input  logic                pwm_g_n,
    input  logic                pwm_b_n,
    output logic [PWM_BITS-1:0] r_int,
    output logic [PWM_BITS-1:0] g_int,
    output logic [PWM_BITS-1:0] b_int,
    output logic [2:0]          sector,
    output logic                meas_valid,
    output logic                locked
);

    localparam int FRAME_CLKS = (1 << PWM_BITS) * STEP_CLKS;
    localparam int ACC_W      = $clog2(FRAME_CLKS + 1);
    localparam int WIN_W      = $clog2(FRAME_CLKS);
    localparam int FL_W       = $clog2(SYNC_STAGES + 1);

    dec_state_t       r_state;
    dec_state_t       w_state_next;
    logic [FL_W-1:0]  r_flush_cnt;
    logic [WIN_W-1:0] r_win_cnt;
    logic             w_clear;
    logic             w_terminal;

    pwm_int_t w_red;
    pwm_int_t w_grn;
    pwm_int_t w_blu;

    pwm_int_t r_red;
    pwm_int_t r_grn;
    pwm_int_t r_blu;
    sector_t  r_sector;
    logic     r_meas_valid;
    logic     r_locked;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= FLUSH;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FLUSH:   if (r_flush_cnt == FL_W'(SYNC_STAGES - 1)) w_state_next = ACQ;
            ACQ:     w_state_next = ACQ;
            default: w_state_next = FLUSH;
        endcase
    end

    always_comb begin
        w_clear    = (r_state == FLUSH);
        w_terminal = (r_state == ACQ) && (r_win_cnt == '1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          r_flush_cnt <= '0;
        else if (w_clear) r_flush_cnt <= r_flush_cnt + 1'b1;
    end

    // FRAME_CLKS is a power of two, so the natural counter wrap is the window wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          r_win_cnt <= '0;
        else if (w_clear) r_win_cnt <= '0;
        else              r_win_cnt <= r_win_cnt + 1'b1;
    end

    pwm_duty_meter #(.STEP_CLKS(STEP_CLKS), .SYNC_STAGES(SYNC_STAGES), .ACC_W(ACC_W)) u_meter_r (
        .CLK(CLK), .RST(RST), .i_line_n(pwm_r_n),
        .i_clear(w_clear), .i_terminal(w_terminal), .o_int(w_red)
    );

    pwm_duty_meter #(.STEP_CLKS(STEP_CLKS), .SYNC_STAGES(SYNC_STAGES), .ACC_W(ACC_W)) u_meter_g (
        .CLK(CLK), .RST(RST), .i_line_n(pwm_g_n),
        .i_clear(w_clear), .i_terminal(w_terminal), .o_int(w_grn)
    );

    pwm_duty_meter #(.STEP_CLKS(STEP_CLKS), .SYNC_STAGES(SYNC_STAGES), .ACC_W(ACC_W)) u_meter_b (
        .CLK(CLK), .RST(RST), .i_line_n(pwm_b_n),
        .i_clear(w_clear), .i_terminal(w_terminal), .o_int(w_blu)
    );

    // Published values only change on the terminal edge of a window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_red        <= '0;
            r_grn        <= '0;
            r_blu        <= '0;
            r_sector     <= SEC_NONE;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_meas_valid <= w_terminal;
            if (w_terminal) begin
                r_red    <= w_red;
                r_grn    <= w_grn;
                r_blu    <= w_blu;
                r_sector <= sector_of(w_red, w_grn, w_blu);
                r_locked <= 1'b1;
            end
        end
    end

    assign r_int      = r_red;
    assign g_int      = r_grn;
    assign b_int      = r_blu;
    assign sector     = r_sector;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// Scoreboard bench: a full-size decoder checks reset and window timing, a
// small-step decoder covers duty, rounding, phase, sector and hue behaviour.
module tb_rgb_pwm_decoder;
    import rgb_pwm_pkg::*;

    localparam int SYNC      = 2;
    localparam int BIG_STEP  = 512;
    localparam int BIG_FRAME = 16 * BIG_STEP;
    localparam int SM_STEP   = 16;
    localparam int SM_FRAME  = 16 * SM_STEP;

    typedef struct {
        bit chk;
        int r;
        int g;
        int b;
        int sec;
    } exp_t;

    logic clk;
    logic rst_big;
    logic rst_sm;
    logic pwm_r_n;
    logic pwm_g_n;
    logic pwm_b_n;

    logic [3:0] r_big, g_big, b_big, r_sm, g_sm, b_sm;
    logic [2:0] sec_big, sec_sm;
    logic       mv_big, mv_sm, lk_big, lk_sm;

    exp_t q_big[$];
    exp_t q_sm[$];
    int   n_total = 0;
    int   n_pass  = 0;

    int low_r = 0;
    int low_g = 0;
    int low_b = 0;
    int phase = 0;
    int frame_len = BIG_FRAME;
    int t = 0;

    rgb_pwm_decoder #(.STEP_CLKS(BIG_STEP), .SYNC_STAGES(SYNC)) u_dut_big (
        .CLK(clk), .RST(rst_big), .pwm_r_n(pwm_r_n), .pwm_g_n(pwm_g_n), .pwm_b_n(pwm_b_n),
        .r_int(r_big), .g_int(g_big), .b_int(b_big), .sector(sec_big),
        .meas_valid(mv_big), .locked(lk_big)
    );

    rgb_pwm_decoder #(.STEP_CLKS(SM_STEP), .SYNC_STAGES(SYNC)) u_dut_small (
        .CLK(clk), .RST(rst_sm), .pwm_r_n(pwm_r_n), .pwm_g_n(pwm_g_n), .pwm_b_n(pwm_b_n),
        .r_int(r_sm), .g_int(g_sm), .b_int(b_sm), .sector(sec_sm),
        .meas_valid(mv_sm), .locked(lk_sm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Periodic pattern: each line is low for low_x cycles of every frame_len.
    initial begin
        pwm_r_n = 1'b1;
        pwm_g_n = 1'b1;
        pwm_b_n = 1'b1;
        forever begin
            int pos;
            @(posedge clk);
            #1;
            t++;
            pos = (t + phase) % frame_len;
            pwm_r_n = !(pos < low_r);
            pwm_g_n = !(pos < low_g);
            pwm_b_n = !(pos < low_b);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mv_big === 1'b1) begin
            if (q_big.size() == 0) check("big_unexpected_strobe", 1, 0);
            else begin
                e = q_big.pop_front();
                if (e.chk) begin
                    check("big_r_int", int'(r_big), e.r);
                    check("big_g_int", int'(g_big), e.g);
                    check("big_b_int", int'(b_big), e.b);
                    check("big_sector", int'(sec_big), e.sec);
                    check("big_locked", int'(lk_big), 1);
                end
            end
        end
        if (mv_sm === 1'b1) begin
            if (q_sm.size() == 0) check("sm_unexpected_strobe", 1, 0);
            else begin
                e = q_sm.pop_front();
                if (e.chk) begin
                    check("sm_r_int", int'(r_sm), e.r);
                    check("sm_g_int", int'(g_sm), e.g);
                    check("sm_b_int", int'(b_sm), e.b);
                    check("sm_sector", int'(sec_sm), e.sec);
                    check("sm_locked", int'(lk_sm), 1);
                end
            end
        end
    end

    // Returns the number of negedges waited; also checks the strobe is one cycle wide.
    task automatic wait_strobe(input bit big, input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if ((big ? mv_big : mv_sm) === 1'b1) break;
        end
        check(big ? "big_strobe_seen" : "sm_strobe_seen", int'(big ? mv_big : mv_sm), 1);
        @(negedge clk);
        check(big ? "big_strobe_width" : "sm_strobe_width", int'(big ? mv_big : mv_sm), 0);
        #1;
    endtask

    task automatic check_reset_values(input bit big, input string tag);
        check({tag, "_r"},      int'(big ? r_big : r_sm), 0);
        check({tag, "_g"},      int'(big ? g_big : g_sm), 0);
        check({tag, "_b"},      int'(big ? b_big : b_sm), 0);
        check({tag, "_sector"}, int'(big ? sec_big : sec_sm), 7);
        check({tag, "_valid"},  int'(big ? mv_big : mv_sm), 0);
        check({tag, "_locked"}, int'(big ? lk_big : lk_sm), 0);
    endtask

    // The window in progress when the pattern changes is mixed and is skipped.
    task automatic run_vec(input string tag, input int lr, input int lg, input int lb, input int ph,
                           input int er, input int eg, input int eb, input int es);
        int cyc;
        low_r = lr;
        low_g = lg;
        low_b = lb;
        phase = ph;
        q_sm.push_back('{chk: 1'b0, r: 0, g: 0, b: 0, sec: 0});
        q_sm.push_back('{chk: 1'b1, r: er, g: eg, b: eb, sec: es});
        wait_strobe(1'b0, SM_FRAME + 8, cyc);
        wait_strobe(1'b0, SM_FRAME + 8, cyc);
        // One cycle of the gap is spent in the strobe-width check.
        check({tag, "_period"}, cyc, SM_FRAME - 1);
    endtask

    function automatic void hue_rgb(input int h, output int r, output int g, output int b);
        int up;
        int dn;
        up = (h % 60) / 4;
        dn = 15 - up;
        case (h / 60)
            0:       begin r = 15; g = up; b = 0;  end
            1:       begin r = dn; g = 15; b = 0;  end
            2:       begin r = 0;  g = 15; b = up; end
            3:       begin r = 0;  g = dn; b = 15; end
            4:       begin r = up; g = 0;  b = 15; end
            default: begin r = 15; g = 0;  b = dn; end
        endcase
    endfunction

    initial begin
        int cyc;
        int hr, hg, hb, hs;
        rst_big = 1'b1;
        rst_sm  = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values(1'b1, "big_reset");
        check_reset_values(1'b0, "sm_reset");

        // Full-size decoder: idle lines, first strobe latency.
        q_big.push_back('{chk: 1'b1, r: 0, g: 0, b: 0, sec: 7});
        rst_big = 1'b0;
        wait_strobe(1'b1, BIG_FRAME + SYNC + 16, cyc);
        check("big_first_strobe_latency", cyc, BIG_FRAME + SYNC);

        // R always low, G low 7 steps, B high.
        low_r = BIG_FRAME;
        low_g = 7 * BIG_STEP;
        low_b = 0;
        q_big.push_back('{chk: 1'b0, r: 0, g: 0, b: 0, sec: 0});
        q_big.push_back('{chk: 1'b1, r: 15, g: 7, b: 0, sec: 0});
        wait_strobe(1'b1, BIG_FRAME + 16, cyc);
        wait_strobe(1'b1, BIG_FRAME + 16, cyc);
        check("big_window_period", cyc, BIG_FRAME - 1);

        // Reset at win_cnt=4000: the strobe cycle had win_cnt=0, we are in cycle 1.
        repeat (3999) @(negedge clk);
        rst_big = 1'b1;
        #1;
        check_reset_values(1'b1, "big_midreset");
        repeat (2) @(negedge clk);
        q_big.push_back('{chk: 1'b1, r: 15, g: 7, b: 0, sec: 0});
        rst_big = 1'b0;
        wait_strobe(1'b1, BIG_FRAME + SYNC + 16, cyc);
        check("big_post_reset_latency", cyc, BIG_FRAME + SYNC);
        rst_big = 1'b1;

        // Small-step decoder from here on.
        @(negedge clk);
        low_r = 0;
        low_g = 0;
        low_b = 0;
        phase = 0;
        frame_len = SM_FRAME;
        repeat (4) @(negedge clk);
        q_sm.push_back('{chk: 1'b1, r: 0, g: 0, b: 0, sec: 7});
        rst_sm = 1'b0;
        wait_strobe(1'b0, SM_FRAME + SYNC + 16, cyc);
        check("sm_first_strobe_latency", cyc, SM_FRAME + SYNC);

        run_vec("duty_r15_g7", SM_FRAME, 7 * SM_STEP, 0, 0, 15, 7, 0, 0);
        run_vec("round_below", 0, 7 * SM_STEP + SM_STEP / 2 - 1, 0, 0, 0, 7, 0, 7);
        run_vec("round_half",  0, 7 * SM_STEP + SM_STEP / 2,     0, 0, 0, 8, 0, 7);
        run_vec("round_sat",   SM_FRAME - SM_STEP / 2 - 1, 7, 8, 0, 15, 0, 1, 5);

        for (int i = 0; i < 4; i++) begin
            run_vec("phase_offset", 100, 200, 37, int'($urandom_range(0, SM_FRAME - 1)), 6, 13, 2, 7);
        end

        run_vec("sec0",     15 * SM_STEP, 8 * SM_STEP,  0,            0, 15, 8,  0,  0);
        run_vec("sec1",     8 * SM_STEP,  15 * SM_STEP, 0,            0, 8,  15, 0,  1);
        run_vec("sec2",     0,            15 * SM_STEP, 4 * SM_STEP,  0, 0,  15, 4,  2);
        run_vec("sec3",     0,            4 * SM_STEP,  15 * SM_STEP, 0, 0,  4,  15, 3);
        run_vec("sec4",     6 * SM_STEP,  0,            15 * SM_STEP, 0, 6,  0,  15, 4);
        run_vec("sec5",     15 * SM_STEP, 0,            9 * SM_STEP,  0, 15, 0,  9,  5);
        run_vec("sec_grey", 5 * SM_STEP,  5 * SM_STEP,  5 * SM_STEP,  0, 5,  5,  5,  7);
        run_vec("sec_white", SM_FRAME, SM_FRAME, SM_FRAME, 0, 15, 15, 15, 7);

        for (int h = 0; h < 360; h += 30) begin
            hue_rgb(h, hr, hg, hb);
            hs = int'(sector_of(4'(hr), 4'(hg), 4'(hb)));
            run_vec("hue", hr * SM_STEP, hg * SM_STEP, hb * SM_STEP, 0, hr, hg, hb, hs);
        end

        rst_sm = 1'b1;
        repeat (4) @(negedge clk);
        check("big_queue_drained", q_big.size(), 0);
        check("sm_queue_drained", q_sm.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
